l1d_rxdat_linefill: RTL and testbench
=====================================

Name: l1d_rxdat_linefill

Overview:
- Receive-side CHI DAT link endpoint for L1D linefills. Sits downstream of the CHI interconnect and upstream of the MSHR / data-ram write path.
- Grants L-credits to the sender and buffers incoming data flits in a credit-sized FIFO.
- Drains the FIFO beat-by-beat as data-ram write requests.
- Counts beats per MSHR id and pulses linefill_done_en/linefill_done_id to the MSHR when a line's final beat has been written.

Parameters:
- MSHR_ENTRY_NUM, 8, number of MSHR entries / legal txn ids
- MSHR_ID_WIDTH, 3, width of txn id, equals clog2(MSHR_ENTRY_NUM)
- BEAT_NUM, 2, data beats per cache line
- BEAT_ID_WIDTH, 1, width of beat index, equals clog2(BEAT_NUM), min 1
- DATA_WIDTH, 256, bits per beat
- CRD_NUM, 4, L-credits and FIFO depth, power of 2, >=2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rxdat_flitv  in  1  DAT flit valid; consumes one sender credit
- rxdat_txnid  in  MSHR_ID_WIDTH  owning MSHR id
- rxdat_dataid  in  BEAT_ID_WIDTH  beat index within line
- rxdat_data  in  DATA_WIDTH  beat data
- rxdat_lcrdv  out  1  one L-credit granted to sender this cycle
- lf_wr_vld  out  1  data-ram linefill write request valid
- lf_wr_rdy  in  1  data-ram write ready
- lf_wr_id  out  MSHR_ID_WIDTH  MSHR id of head beat
- lf_wr_beat  out  BEAT_ID_WIDTH  beat index of head beat
- lf_wr_data  out  DATA_WIDTH  head beat data
- linefill_done_en  out  1  one-cycle pulse: line complete in data ram
- linefill_done_id  out  MSHR_ID_WIDTH  MSHR id of completed line
- err_crd_ovf  out  1  sticky: flit received with no outstanding credit

Behaviour:
- Reset (rst_n low at posedge):
  - crd_out=0, fifo_cnt=0, rd/wr pointers=0, all beat counters=0, err_crd_ovf=0.
  - rxdat_lcrdv=0, lf_wr_vld=0, linefill_done_en=0, linefill_done_id=0.
  - A reset mid-transfer discards buffered beats and partial counts.
- Credit state:
  - crd_out counts credits held by the sender, 0..CRD_NUM.
  - rxdat_lcrdv = (crd_out + fifo_cnt < CRD_NUM), decoded from flops only.
  - At most one credit per cycle.
  - crd_out_next = crd_out + rxdat_lcrdv - (rxdat_flitv && crd_out!=0).
  - Invariant: crd_out + fifo_cnt <= CRD_NUM at all times.
  - After reset release, lcrdv is high for exactly CRD_NUM consecutive cycles when no flits arrive.
- Flit accept:
  - If rxdat_flitv && crd_out!=0: write {txnid, dataid, data} at wr_ptr and increment fifo_cnt.
  - If rxdat_flitv && crd_out==0: drop the flit, set err_crd_ovf (cleared only by reset), no state change.
- Write side:
  - lf_wr_vld = fifo_cnt!=0; lf_wr_id/beat/data come from the head entry.
  - A flit accepted at cycle T is visible on lf_wr_* at T+1; there is no combinational bypass.
  - Payload is held stable while vld && !rdy.
  - Pop on lf_wr_vld && lf_wr_rdy.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - A pop at T frees one slot, so rxdat_lcrdv rises at T+1 provided crd_out+fifo_cnt < CRD_NUM.
  - Pointers wrap modulo CRD_NUM.
- Beat counting:
  - Each MSHR id has a counter, 0..BEAT_NUM-1, incremented on pop of a beat with that id.
  - Beats may be written in any dataid order; the counter counts beats, not indices.
  - If the popped beat takes the counter to BEAT_NUM, the counter resets to 0 and linefill_done_en=1 with linefill_done_id=id at T+1, for one cycle.
  - At most one done pulse per cycle, since there is at most one pop per cycle.
  - Interleaved beats of different ids complete independently.
- A simultaneous flit accept and lcrdv grant in one cycle nets crd_out unchanged.

Test Plan:
- Reset release, no flits, lf_wr_rdy=1 -> rxdat_lcrdv high cycles 1-4 after release then low; no lf_wr_vld; done never pulses.
- After 4 credits, send id=3 beats dataid 0 then 1 back-to-back, rdy=1 -> lf_wr_vld high 2 cycles (id 3, beats 0,1); linefill_done_en=1 with id=3 one cycle after second pop; two lcrdv pulses follow the pops.
- Hold lf_wr_rdy=0, send 4 flits (ids 1,2,1,2) -> fifo full, lcrdv stays 0, payload stable. Then rdy=1 -> done id=1 then id=2 on consecutive pops' next cycles; 4 credits returned.
- With crd_out=0, assert rxdat_flitv -> flit not written, lf_wr_vld unchanged, err_crd_ovf=1 and remains 1 until reset.
- Send id=5 dataid 1 before dataid 0 -> both written in arrival order; single done pulse for id 5 after second write.
- Assert rst_n=0 with 2 beats buffered and a partial count on id 0 -> next cycle all outputs 0; after release, one beat for id 0 does not produce done.

Source files
------------

// File: rtl/l1d_rxdat_linefill_if.sv
// l1d_rxdat_linefill_if
//   Bundles the CHI DAT receive link and the data-ram linefill write port
//   of the L1D linefill receiver.
//   slave  : the receiver (flit/ready in, credit/write/done/error out)
//   master : the environment driving flits and accepting ram writes
//   rxdat_*          : DAT flit in, L-credit out
//   lf_wr_*          : data-ram write request, valid/ready
//   linefill_done_*  : line-complete pulse to the MSHR
//   err_crd_ovf      : sticky credit-overflow flag
interface l1d_rxdat_linefill_if #(
   parameter int MSHR_ID_WIDTH = 3,
   parameter int BEAT_ID_WIDTH = 1,
   parameter int DATA_WIDTH    = 256
);
   logic                     rxdat_flitv;
   logic [MSHR_ID_WIDTH-1:0] rxdat_txnid;
   logic [BEAT_ID_WIDTH-1:0] rxdat_dataid;
   logic [DATA_WIDTH-1:0]    rxdat_data;
   logic                     rxdat_lcrdv;
   logic                     lf_wr_vld;
   logic                     lf_wr_rdy;
   logic [MSHR_ID_WIDTH-1:0] lf_wr_id;
   logic [BEAT_ID_WIDTH-1:0] lf_wr_beat;
   logic [DATA_WIDTH-1:0]    lf_wr_data;
   logic                     linefill_done_en;
   logic [MSHR_ID_WIDTH-1:0] linefill_done_id;
   logic                     err_crd_ovf;

   modport slave (
      input  rxdat_flitv, rxdat_txnid, rxdat_dataid, rxdat_data, lf_wr_rdy,
      output rxdat_lcrdv, lf_wr_vld, lf_wr_id, lf_wr_beat, lf_wr_data,
             linefill_done_en, linefill_done_id, err_crd_ovf
   );

   modport master (
      output rxdat_flitv, rxdat_txnid, rxdat_dataid, rxdat_data, lf_wr_rdy,
      input  rxdat_lcrdv, lf_wr_vld, lf_wr_id, lf_wr_beat, lf_wr_data,
             linefill_done_en, linefill_done_id, err_crd_ovf
   );
endinterface

// File: rtl/l1d_rxdat_linefill.sv
// l1d_rxdat_linefill
//   Receive-side CHI DAT endpoint for L1D linefills. Grants L-credits,
//   buffers accepted flits in a credit-sized FIFO, drains them as data-ram
//   writes and pulses linefill_done when the last beat of a line is written.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : l1d_rxdat_linefill_if.slave (DAT link, ram write, done, error)
module l1d_rxdat_linefill #(
   parameter int MSHR_ENTRY_NUM = 8,
   parameter int MSHR_ID_WIDTH  = 3,
   parameter int BEAT_NUM       = 2,
   parameter int BEAT_ID_WIDTH  = 1,
   parameter int DATA_WIDTH     = 256,
   parameter int CRD_NUM        = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   l1d_rxdat_linefill_if.slave    bus
);
   localparam int PW = $clog2(CRD_NUM);
   localparam int HW = MSHR_ID_WIDTH + BEAT_ID_WIDTH;
   localparam int EW = HW + DATA_WIDTH;
   localparam logic [PW+1:0]          CRD_MAX   = (PW+2)'(CRD_NUM);
   localparam logic [BEAT_ID_WIDTH-1:0] LAST_BEAT = BEAT_ID_WIDTH'(BEAT_NUM - 1);

   logic                     run;
   logic [PW:0]              crd_out;
   logic [PW:0]              fifo_cnt;
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [EW-1:0]            mem [CRD_NUM];
   logic [BEAT_ID_WIDTH-1:0] beat_cnt [MSHR_ENTRY_NUM];
   logic                     err_q;
   logic                     done_en_q;
   logic [MSHR_ID_WIDTH-1:0] done_id_q;

   logic [PW+1:0]            used;
   logic                     grant;
   logic                     accept;
   logic                     drop;
   logic                     vld;
   logic                     pop;
   logic [EW-1:0]            head;
   logic [MSHR_ID_WIDTH-1:0] head_id;
   logic [BEAT_ID_WIDTH-1:0] head_beat;

   // run keeps the credit grant quiet during reset and for the release edge,
   // so the grant is a pure decode of flops.
   assign used   = {1'b0, crd_out} + {1'b0, fifo_cnt};
   assign grant  = run && (used < CRD_MAX);
   assign accept = bus.rxdat_flitv && (crd_out != '0);
   assign drop   = bus.rxdat_flitv && (crd_out == '0);
   assign vld    = (fifo_cnt != '0);
   assign pop    = vld && bus.lf_wr_rdy;

   assign head                = mem[rd_ptr];
   assign {head_id, head_beat} = head[EW-1 -: HW];

   // Payload is forced to zero when nothing is buffered, so stale entries
   // never leak onto the write port (including right after a reset).
   assign bus.rxdat_lcrdv      = grant;
   assign bus.lf_wr_vld        = vld;
   assign bus.lf_wr_id         = vld ? head_id : '0;
   assign bus.lf_wr_beat       = vld ? head_beat : '0;
   assign bus.lf_wr_data       = vld ? head[DATA_WIDTH-1:0] : '0;
   assign bus.linefill_done_en = done_en_q;
   assign bus.linefill_done_id = done_id_q;
   assign bus.err_crd_ovf      = err_q;

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= {bus.rxdat_txnid, bus.rxdat_dataid, bus.rxdat_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run       <= 1'b0;
         crd_out   <= '0;
         fifo_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         err_q     <= 1'b0;
         done_en_q <= 1'b0;
         done_id_q <= '0;
         for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
            beat_cnt[i] <= '0;
         end
      end else begin
         run <= 1'b1;

         case ({grant, accept})
            2'b10:   crd_out <= crd_out + (PW+1)'(1);
            2'b01:   crd_out <= crd_out - (PW+1)'(1);
            default: crd_out <= crd_out;
         endcase

         case ({accept, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         if (drop)   err_q  <= 1'b1;

         // Beats are counted, not indexed, so any dataid order completes a line.
         done_en_q <= 1'b0;
         if (pop) begin
            if (beat_cnt[head_id] == LAST_BEAT) begin
               beat_cnt[head_id] <= '0;
               done_en_q         <= 1'b1;
               done_id_q         <= head_id;
            end else begin
               beat_cnt[head_id] <= beat_cnt[head_id] + BEAT_ID_WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_l1d_rxdat_linefill.sv
// tb_l1d_rxdat_linefill
//   Directed stimulus for the linefill receiver. Each sent flit pushes its
//   expected ram write (and whether it completes a line) into a queue; a
//   negedge monitor pops and compares on every write handshake and on every
//   done pulse, including done latency of one cycle after the pop.
module tb_l1d_rxdat_linefill;
   localparam int CRD_NUM = 4;

   typedef struct {
      logic [2:0]   id;
      logic [0:0]   beat;
      logic [255:0] data;
      bit           done;
   } wr_exp_t;

   typedef struct {
      logic [2:0] id;
      int         cyc;
   } done_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   l1d_rxdat_linefill_if bus ();

   l1d_rxdat_linefill dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   wr_exp_t   exp_q[$];
   done_exp_t done_q[$];
   wr_exp_t   m_e;
   done_exp_t m_d;
   int vectors     = 0;
   int miscompares = 0;
   int tb_crd      = 0;
   int cyc         = 0;

   task automatic check(string name, logic [255:0] act, logic [255:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [255:0] pat(logic [2:0] id, logic beat);
      return {8{4'hD, 1'b0, id, 7'h00, beat, 16'hBEEF}};
   endfunction

   // Monitor: credit tracking and scoreboard compare.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (bus.rxdat_lcrdv) tb_crd++;
         if (bus.lf_wr_vld && bus.lf_wr_rdy) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pop: got id %0h beat %0h, expected no write",
                        bus.lf_wr_id, bus.lf_wr_beat);
            end else begin
               m_e = exp_q.pop_front();
               check("wr_id",   bus.lf_wr_id,   m_e.id);
               check("wr_beat", bus.lf_wr_beat, m_e.beat);
               check("wr_data", bus.lf_wr_data, m_e.data);
               if (m_e.done) done_q.push_back('{m_e.id, cyc + 1});
            end
         end
         if (bus.linefill_done_en) begin
            if (done_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got id %0h, expected no pulse",
                        bus.linefill_done_id);
            end else begin
               m_d = done_q.pop_front();
               check("done_id",  bus.linefill_done_id, m_d.id);
               check("done_cyc", cyc, m_d.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [2:0] id, logic beat, bit done);
      int budget = 0;
      while (tb_crd == 0 && budget < 200) begin
         tick();
         budget++;
      end
      if (tb_crd == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL credit_wait: got 0 credits, expected at least 1");
         return;
      end
      bus.rxdat_flitv  = 1'b1;
      bus.rxdat_txnid  = id;
      bus.rxdat_dataid = beat;
      bus.rxdat_data   = pat(id, beat);
      tb_crd--;
      exp_q.push_back('{id, beat, pat(id, beat), done});
      tick();
      bus.rxdat_flitv = 1'b0;
   endtask

   task automatic wait_drain();
      int budget = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && budget < 100) begin
         tick();
         budget++;
      end
      tick();
      check("drained", exp_q.size() + done_q.size(), 0);
   endtask

   task automatic wait_credits();
      int budget = 0;
      while (tb_crd != CRD_NUM && budget < 50) begin
         tick();
         budget++;
      end
      check("credits_held", tb_crd, CRD_NUM);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      bus.rxdat_flitv  = 1'b0;
      bus.rxdat_txnid  = '0;
      bus.rxdat_dataid = '0;
      bus.rxdat_data   = '0;
      bus.lf_wr_rdy    = 1'b1;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_lcrdv", bus.rxdat_lcrdv, 0);
      check("rst_vld",   bus.lf_wr_vld, 0);
      check("rst_done",  bus.linefill_done_en, 0);
      check("rst_err",   bus.err_crd_ovf, 0);
      tick();
      rst_n = 1'b1;

      // Credits after release: high for exactly CRD_NUM cycles
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("init_lcrdv", bus.rxdat_lcrdv, (i >= 1 && i <= 4) ? 1 : 0);
         check("init_vld",   bus.lf_wr_vld, 0);
      end
      tick();
      wait_credits();

      // One line, in order, back-to-back
      send(3'd3, 1'b0, 1'b0);
      send(3'd3, 1'b1, 1'b1);
      wait_drain();
      wait_credits();

      // Back-pressure: fill FIFO, payload held, then interleaved completion
      bus.lf_wr_rdy = 1'b0;
      send(3'd1, 1'b0, 1'b0);
      send(3'd2, 1'b0, 1'b0);
      send(3'd1, 1'b1, 1'b1);
      send(3'd2, 1'b1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("full_lcrdv", bus.rxdat_lcrdv, 0);
         check("full_vld",   bus.lf_wr_vld, 1);
         check("hold_id",    bus.lf_wr_id, 3'd1);
         check("hold_beat",  bus.lf_wr_beat, 1'b0);
         check("hold_data",  bus.lf_wr_data, pat(3'd1, 1'b0));
      end
      tick();
      bus.lf_wr_rdy = 1'b1;
      wait_drain();
      wait_credits();

      // Credit overflow: spend all credits, then send one more flit
      bus.lf_wr_rdy = 1'b0;
      send(3'd4, 1'b0, 1'b0);
      send(3'd4, 1'b1, 1'b1);
      send(3'd6, 1'b0, 1'b0);
      send(3'd6, 1'b1, 1'b1);
      bus.rxdat_flitv  = 1'b1;
      bus.rxdat_txnid  = 3'd7;
      bus.rxdat_dataid = 1'b0;
      bus.rxdat_data   = {256{1'b1}};
      tick();
      bus.rxdat_flitv = 1'b0;
      @(negedge clk);
      check("ovf_err",  bus.err_crd_ovf, 1);
      check("ovf_vld",  bus.lf_wr_vld, 1);
      check("ovf_id",   bus.lf_wr_id, 3'd4);
      check("ovf_data", bus.lf_wr_data, pat(3'd4, 1'b0));
      tick();
      bus.lf_wr_rdy = 1'b1;
      wait_drain();
      wait_credits();
      check("err_sticky", bus.err_crd_ovf, 1);

      // Out-of-order dataid within a line
      send(3'd5, 1'b1, 1'b0);
      send(3'd5, 1'b0, 1'b1);
      wait_drain();
      wait_credits();
      check("err_still", bus.err_crd_ovf, 1);

      // Reset mid-transfer: partial count on id 0, two beats buffered
      send(3'd0, 1'b0, 1'b0);
      wait_drain();
      bus.lf_wr_rdy = 1'b0;
      send(3'd2, 1'b0, 1'b0);
      send(3'd3, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      tb_crd = 0;
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      check("mid_lcrdv",   bus.rxdat_lcrdv, 0);
      check("mid_vld",     bus.lf_wr_vld, 0);
      check("mid_id",      bus.lf_wr_id, 0);
      check("mid_beat",    bus.lf_wr_beat, 0);
      check("mid_data",    bus.lf_wr_data, 0);
      check("mid_done",    bus.linefill_done_en, 0);
      check("mid_done_id", bus.linefill_done_id, 0);
      check("mid_err",     bus.err_crd_ovf, 0);
      tick();
      rst_n = 1'b1;
      bus.lf_wr_rdy = 1'b1;
      send(3'd0, 1'b1, 1'b0);
      repeat (10) tick();
      wait_drain();
      wait_credits();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
